// File: rtl/lv_mult_sched.sv
// rtl/lv_mult_sched.sv - time-shared VX/VY/WZ fixed-point multiply scheduler (optional LV_MULT_SCHED_SATURATE_EN)
module lv_mult_sched #(
    parameter int                  N_WIDTH        = 17,
    parameter int                  Q_WIDTH        = 8,
    parameter logic [N_WIDTH-1:0]  K_VXY          = 17'h000E8,
    parameter logic [N_WIDTH-1:0]  K_WZ           = 17'h0000E,
    parameter int                  TIMEOUT_CYCLES = 64
) (
    input  logic               LV_MULT_SCHED_CLOCK_50,
    input  logic               LV_MULT_SCHED_RESET_InLow,
    input  logic               LV_MULT_SCHED_valid_InHigh,
    output logic               LV_MULT_SCHED_ready_OutHigh,
    input  logic [N_WIDTH-1:0] LV_MULT_SCHED_SUMVX_InBus,
    input  logic [N_WIDTH-1:0] LV_MULT_SCHED_SUMVY_InBus,
    input  logic [N_WIDTH-1:0] LV_MULT_SCHED_SUMWZ_InBus,
    output logic               LV_MULT_SCHED_MULTSTART_Out,
    output logic [N_WIDTH-1:0] LV_MULT_SCHED_MULTA_OutBus,
    output logic [N_WIDTH-1:0] LV_MULT_SCHED_MULTB_OutBus,
    input  logic               LV_MULT_SCHED_MULTDONE_InHigh,
    input  logic [N_WIDTH-1:0] LV_MULT_SCHED_MULTRES_InBus,
    input  logic               LV_MULT_SCHED_MULTOVF_InHigh,
    output logic [N_WIDTH-1:0] LV_MULT_SCHED_VX_OutBus,
    output logic [N_WIDTH-1:0] LV_MULT_SCHED_VY_OutBus,
    output logic [N_WIDTH-1:0] LV_MULT_SCHED_WZ_OutBus,
    output logic               LV_MULT_SCHED_valid_OutHigh,
    output logic [2:0]         LV_MULT_SCHED_ovf_OutBus,
    output logic               LV_MULT_SCHED_timeout_OutHigh
);

    localparam int            CW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MASK  = CW'(2);
    localparam logic [CW-1:0] CNT_LAST  = CW'(TIMEOUT_CYCLES - 1);

    // The fraction width only matters to the external multiplier; reject nonsense at elaboration.
    if (Q_WIDTH >= N_WIDTH - 1) begin : g_q_width_check
        $error("Q_WIDTH must leave at least one integer magnitude bit");
    end

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        PUBLISH = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         ch_q, ch_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [N_WIDTH-1:0] op_q [3];
    logic [N_WIDTH-1:0] op_d [3];
    logic [N_WIDTH-1:0] res_q [3];
    logic [N_WIDTH-1:0] res_d [3];
    logic [2:0]         ovf_q, ovf_d;
    logic               to_q, to_d;
    logic               ready_q, ready_d;
    logic               start_q, start_d;
    logic               valid_q, valid_d;
    logic [N_WIDTH-1:0] mult_a_q, mult_a_d;
    logic [N_WIDTH-1:0] mult_b_q, mult_b_d;
    logic [N_WIDTH-1:0] vx_q, vx_d, vy_q, vy_d, wz_q, wz_d;
    logic [N_WIDTH-1:0] cap_val;

    // Value written into the result shadow: raw product, or clamped magnitude on overflow.
    always_comb begin
`ifdef LV_MULT_SCHED_SATURATE_EN
        if (LV_MULT_SCHED_MULTOVF_InHigh) begin
            cap_val = {LV_MULT_SCHED_MULTRES_InBus[N_WIDTH-1], {(N_WIDTH-1){1'b1}}};
        end else begin
            cap_val = LV_MULT_SCHED_MULTRES_InBus;
        end
`else
        cap_val = LV_MULT_SCHED_MULTRES_InBus;
`endif
    end

    // Next-state logic: sequence VX -> VY -> WZ through the shared multiplier, then publish.
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        res_d    = res_q;
        ovf_d    = ovf_q;
        to_d     = to_q;
        vx_d     = vx_q;
        vy_d     = vy_q;
        wz_d     = wz_q;
        valid_d  = 1'b0;
        mult_a_d = mult_a_q;
        mult_b_d = mult_b_q;

        case (state_q)
            IDLE: begin
                if (LV_MULT_SCHED_valid_InHigh && ready_q) begin
                    op_d[0] = LV_MULT_SCHED_SUMVX_InBus;
                    op_d[1] = LV_MULT_SCHED_SUMVY_InBus;
                    op_d[2] = LV_MULT_SCHED_SUMWZ_InBus;
                    ovf_d   = 3'b000;
                    to_d    = 1'b0;
                    ch_d    = 2'd0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // The first two WAIT cycles may still see the previous product's complete flag.
                if (LV_MULT_SCHED_MULTDONE_InHigh && (cnt_q >= CNT_MASK)) begin
                    state_d = CAPTURE;
                end else if (cnt_q == CNT_LAST) begin
                    to_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            CAPTURE: begin
                case (ch_q)
                    2'd0:    begin res_d[0] = cap_val; ovf_d[0] = LV_MULT_SCHED_MULTOVF_InHigh; end
                    2'd1:    begin res_d[1] = cap_val; ovf_d[1] = LV_MULT_SCHED_MULTOVF_InHigh; end
                    default: begin res_d[2] = cap_val; ovf_d[2] = LV_MULT_SCHED_MULTOVF_InHigh; end
                endcase
                if (ch_q == 2'd2) begin
                    state_d = PUBLISH;
                end else begin
                    ch_d    = ch_q + 2'd1;
                    state_d = ISSUE;
                end
            end
            PUBLISH: begin
                vx_d    = res_q[0];
                vy_d    = res_q[1];
                wz_d    = res_q[2];
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Operands are loaded on entry to ISSUE and held until the product is captured.
        if ((state_d == ISSUE) && (state_q != ISSUE)) begin
            case (ch_d)
                2'd0:    begin mult_a_d = op_d[0]; mult_b_d = K_VXY; end
                2'd1:    begin mult_a_d = op_d[1]; mult_b_d = K_VXY; end
                default: begin mult_a_d = op_d[2]; mult_b_d = K_WZ;  end
            endcase
        end

        start_d = (state_d == ISSUE);
        ready_d = (state_d == IDLE);
    end

    // State and datapath registers; reset discards any partially computed sample.
    always_ff @(posedge LV_MULT_SCHED_CLOCK_50 or negedge LV_MULT_SCHED_RESET_InLow) begin
        if (!LV_MULT_SCHED_RESET_InLow) begin
            state_q  <= IDLE;
            ch_q     <= 2'd0;
            cnt_q    <= '0;
            for (int i = 0; i < 3; i++) begin
                op_q[i]  <= '0;
                res_q[i] <= '0;
            end
            ovf_q    <= 3'b000;
            to_q     <= 1'b0;
            ready_q  <= 1'b1;
            start_q  <= 1'b0;
            valid_q  <= 1'b0;
            mult_a_q <= '0;
            mult_b_q <= '0;
            vx_q     <= '0;
            vy_q     <= '0;
            wz_q     <= '0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            res_q    <= res_d;
            ovf_q    <= ovf_d;
            to_q     <= to_d;
            ready_q  <= ready_d;
            start_q  <= start_d;
            valid_q  <= valid_d;
            mult_a_q <= mult_a_d;
            mult_b_q <= mult_b_d;
            vx_q     <= vx_d;
            vy_q     <= vy_d;
            wz_q     <= wz_d;
        end
    end

    assign LV_MULT_SCHED_ready_OutHigh   = ready_q;
    assign LV_MULT_SCHED_MULTSTART_Out   = start_q;
    assign LV_MULT_SCHED_MULTA_OutBus    = mult_a_q;
    assign LV_MULT_SCHED_MULTB_OutBus    = mult_b_q;
    assign LV_MULT_SCHED_VX_OutBus       = vx_q;
    assign LV_MULT_SCHED_VY_OutBus       = vy_q;
    assign LV_MULT_SCHED_WZ_OutBus       = wz_q;
    assign LV_MULT_SCHED_valid_OutHigh   = valid_q;
    assign LV_MULT_SCHED_ovf_OutBus      = ovf_q;
    assign LV_MULT_SCHED_timeout_OutHigh = to_q;

endmodule

// File: tb/tb_lv_mult_sched.sv
// tb/tb_lv_mult_sched.sv - scoreboard testbench for lv_mult_sched
module tb_lv_mult_sched;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic        ready;
    logic [16:0] sum_vx, sum_vy, sum_wz;
    logic        mstart;
    logic [16:0] ma, mb;
    logic        mdone;
    logic [16:0] mres;
    logic        movf;
    logic [16:0] vx, vy, wz;
    logic        valid_out;
    logic [2:0]  ovf;
    logic        tmo;

    int checks = 0;
    int errors = 0;

    lv_mult_sched dut (
        .LV_MULT_SCHED_CLOCK_50        (clk),
        .LV_MULT_SCHED_RESET_InLow     (rst_n),
        .LV_MULT_SCHED_valid_InHigh    (valid_in),
        .LV_MULT_SCHED_ready_OutHigh   (ready),
        .LV_MULT_SCHED_SUMVX_InBus     (sum_vx),
        .LV_MULT_SCHED_SUMVY_InBus     (sum_vy),
        .LV_MULT_SCHED_SUMWZ_InBus     (sum_wz),
        .LV_MULT_SCHED_MULTSTART_Out   (mstart),
        .LV_MULT_SCHED_MULTA_OutBus    (ma),
        .LV_MULT_SCHED_MULTB_OutBus    (mb),
        .LV_MULT_SCHED_MULTDONE_InHigh (mdone),
        .LV_MULT_SCHED_MULTRES_InBus   (mres),
        .LV_MULT_SCHED_MULTOVF_InHigh  (movf),
        .LV_MULT_SCHED_VX_OutBus       (vx),
        .LV_MULT_SCHED_VY_OutBus       (vy),
        .LV_MULT_SCHED_WZ_OutBus       (wz),
        .LV_MULT_SCHED_valid_OutHigh   (valid_out),
        .LV_MULT_SCHED_ovf_OutBus      (ovf),
        .LV_MULT_SCHED_timeout_OutHigh (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural sign-magnitude multiplier: complete stays high for two cycles after start
    // (stale flag), then drops for the busy period. Fault hooks: hang_at / ovf_at start indices.
    int          start_cnt = 0;
    int          hang_at   = -1;
    int          ovf_at    = -1;
    int          stale     = 0;
    int          busy      = 0;
    logic [31:0] prod;
    assign mdone = (stale > 0) || (busy == 0);

    initial begin
        mres = '0;
        movf = 1'b0;
    end

    always @(posedge clk) begin
        if (stale > 0) stale <= stale - 1;
        if (busy > 0)  busy  <= busy - 1;
        if (mstart) begin
            stale <= 2;
            busy  <= (start_cnt == hang_at) ? 1000000 : 6;
            prod = ({16'b0, ma[15:0]} * {16'b0, mb[15:0]}) >> 8;
            if (start_cnt == ovf_at) begin
                mres <= 17'h1ABCD;
                movf <= 1'b1;
            end else begin
                mres <= {ma[16] ^ mb[16], prod[15:0]};
                movf <= |prod[31:16];
            end
            start_cnt <= start_cnt + 1;
        end
    end

    // Scoreboard queues and monitor.
    logic [33:0] exp_mult[$];
    logic [53:0] exp_res[$];
    int          cyc = 0;
    int          n_starts = 0;
    int          n_valid = 0;
    int          last_start_cyc = 0;
    int          ready_rise_cyc = 0;
    logic        ready_prev = 1'b1;

    always @(negedge clk) begin
        logic [33:0] em;
        logic [53:0] er;
        cyc++;
        if (ready && !ready_prev) ready_rise_cyc = cyc;
        ready_prev = ready;
        if (mstart) begin
            n_starts++;
            last_start_cyc = cyc;
            if (exp_mult.size() == 0) begin
                chk("unexpected_start", {30'b0, ma, mb}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                em = exp_mult.pop_front();
                chk("mult_operands", {30'b0, ma, mb}, {30'b0, em});
            end
        end
        if (valid_out) begin
            n_valid++;
            if (exp_res.size() == 0) begin
                chk("unexpected_valid", {10'b0, vx, vy, wz, ovf}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                er = exp_res.pop_front();
                chk("vx", {47'b0, vx}, {47'b0, er[53:37]});
                chk("vy", {47'b0, vy}, {47'b0, er[36:20]});
                chk("wz", {47'b0, wz}, {47'b0, er[19:3]});
                chk("ovf", {61'b0, ovf}, {61'b0, er[2:0]});
                chk("timeout_on_valid", {63'b0, tmo}, 64'd0);
            end
        end
    end

    task automatic push_mults(input logic [16:0] a0, input logic [16:0] a1,
                              input logic [16:0] a2, input int n);
        if (n > 0) exp_mult.push_back({a0, 17'h000E8});
        if (n > 1) exp_mult.push_back({a1, 17'h000E8});
        if (n > 2) exp_mult.push_back({a2, 17'h0000E});
    endtask

    task automatic push_res(input logic [16:0] x, input logic [16:0] y,
                            input logic [16:0] z, input logic [2:0] o);
        exp_res.push_back({x, y, z, o});
    endtask

    task automatic wait_ready(input int bound);
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while (!ready && n < bound);
        if (!ready) chk("ready_wait_bound", 64'd0, 64'd1);
    endtask

    // Offer a triple once ready is seen; with hold=1 valid stays high carrying junk afterwards.
    task automatic issue(input logic [16:0] x, input logic [16:0] y,
                         input logic [16:0] z, input bit hold);
        wait_ready(400);
        sum_vx = x; sum_vy = y; sum_wz = z;
        valid_in = 1'b1;
        @(posedge clk); #1;
        if (hold) begin
            sum_vx = 17'h1FFFF; sum_vy = 17'h1FFFF; sum_wz = 17'h1FFFF;
        end else begin
            valid_in = 1'b0;
        end
    endtask

    logic [16:0] vec [3][3];
    logic [16:0] res [3][3];
    int          s0, v0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; valid_in = 1'b0;
        sum_vx = '0; sum_vy = '0; sum_wz = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", {63'b0, ready}, 64'd1);
        chk("rst_start", {63'b0, mstart}, 64'd0);
        chk("rst_multab", {30'b0, ma, mb}, 64'd0);
        chk("rst_vel", {13'b0, vx, vy, wz}, 64'd0);
        chk("rst_flags", {59'b0, valid_out, ovf, tmo}, 64'd0);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        #1;
        chk("idle_starts", n_starts, 64'd0);
        chk("idle_ready", {63'b0, ready}, 64'd1);
        chk("idle_vel", {13'b0, vx, vy, wz}, 64'd0);

        // Basic sample: 4.0, -2.0, 8.0
        s0 = n_starts;
        push_mults(17'h00400, 17'h10200, 17'h00800, 3);
        push_res(17'h003A0, 17'h101D0, 17'h00070, 3'b000);
        issue(17'h00400, 17'h10200, 17'h00800, 1'b0);
        wait_ready(400);
        chk("basic_starts", n_starts - s0, 64'd3);
        chk("basic_valids", n_valid, 64'd1);

        // Back-to-back with valid held high and junk present outside IDLE
        vec[0] = '{17'h00100, 17'h00080, 17'h11000}; res[0] = '{17'h000E8, 17'h00074, 17'h100E0};
        vec[1] = '{17'h10300, 17'h00A00, 17'h00100}; res[1] = '{17'h102B8, 17'h00910, 17'h0000E};
        vec[2] = '{17'h02000, 17'h10010, 17'h04000}; res[2] = '{17'h01D00, 17'h1000E, 17'h00380};
        for (int i = 0; i < 3; i++) begin
            push_mults(vec[i][0], vec[i][1], vec[i][2], 3);
            push_res(res[i][0], res[i][1], res[i][2], 3'b000);
            issue(vec[i][0], vec[i][1], vec[i][2], i < 2);
        end
        wait_ready(400);
        chk("b2b_valids", n_valid, 64'd4);

        // Multiplier never completes VY: timeout, no publish, outputs retained
        v0 = n_valid;
        hang_at = start_cnt + 1;
        push_mults(17'h00400, 17'h10200, 17'h00800, 2);
        issue(17'h00400, 17'h10200, 17'h00800, 1'b0);
        wait_ready(400);
        hang_at = -1;
        chk("to_flag", {63'b0, tmo}, 64'd1);
        chk("to_no_valid", n_valid - v0, 64'd0);
        chk("to_retain", {13'b0, vx, vy, wz}, {13'b0, 17'h01D00, 17'h1000E, 17'h00380});
        chk("to_duration", ready_rise_cyc - last_start_cyc, 64'd65);
        push_mults(17'h00400, 17'h10200, 17'h00800, 3);
        push_res(17'h003A0, 17'h101D0, 17'h00070, 3'b000);
        issue(17'h00400, 17'h10200, 17'h00800, 1'b0);
        chk("to_cleared_on_accept", {63'b0, tmo}, 64'd0);
        wait_ready(400);

        // Overflow reported on WZ
        ovf_at = start_cnt + 2;
        push_mults(17'h00400, 17'h10200, 17'h00800, 3);
`ifdef LV_MULT_SCHED_SATURATE_EN
        push_res(17'h003A0, 17'h101D0, 17'h1FFFF, 3'b100);
`else
        push_res(17'h003A0, 17'h101D0, 17'h1ABCD, 3'b100);
`endif
        issue(17'h00400, 17'h10200, 17'h00800, 1'b0);
        wait_ready(400);
        ovf_at = -1;
        chk("ovf_bus", {61'b0, ovf}, 64'd4);

        // Reset during the VY wait
        v0 = n_valid;
        s0 = n_starts;
        push_mults(17'h00100, 17'h00080, 17'h11000, 2);
        issue(17'h00100, 17'h00080, 17'h11000, 1'b0);
        for (int n = 0; n < 100 && n_starts < s0 + 2; n++) @(negedge clk);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vel", {13'b0, vx, vy, wz}, 64'd0);
        chk("mid_rst_flags", {58'b0, ready, valid_out, ovf, tmo}, 64'h20);
        chk("mid_rst_start", {63'b0, mstart}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        chk("post_rst_ready", {63'b0, ready}, 64'd1);
        chk("post_rst_no_valid", n_valid - v0, 64'd0);
        chk("post_rst_starts", n_starts - s0, 64'd2);

        chk("mult_queue_empty", exp_mult.size(), 64'd0);
        chk("res_queue_empty", exp_res.size(), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
